// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: three-master AHB arbiter (round-robin, burst/lock hold, bounded tenure).
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority M0 > M1 > M2 with no tenure limit.
module ahb_rr_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_TENURE     = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HBUSREQ_M0,
  input  logic                  HBUSREQ_M1,
  input  logic                  HBUSREQ_M2,
  input  logic                  HLOCK_M0,
  input  logic                  HLOCK_M1,
  input  logic                  HLOCK_M2,
  input  logic [ADDR_WIDTH-1:0] HADDR_M0,
  input  logic [ADDR_WIDTH-1:0] HADDR_M1,
  input  logic [ADDR_WIDTH-1:0] HADDR_M2,
  input  logic [1:0]            HTRANS_M0,
  input  logic [1:0]            HTRANS_M1,
  input  logic [1:0]            HTRANS_M2,
  input  logic                  HWRITE_M0,
  input  logic                  HWRITE_M1,
  input  logic                  HWRITE_M2,
  input  logic [DATA_WIDTH-1:0] HWDATA_M0,
  input  logic [DATA_WIDTH-1:0] HWDATA_M1,
  input  logic [DATA_WIDTH-1:0] HWDATA_M2,
  input  logic                  HREADY_S,
  output logic                  HGRANT_M0,
  output logic                  HGRANT_M1,
  output logic                  HGRANT_M2,
  output logic [1:0]            HMASTER,
  output logic                  HMASTLOCK,
  output logic [ADDR_WIDTH-1:0] HADDR_S,
  output logic [1:0]            HTRANS_S,
  output logic                  HWRITE_S,
  output logic [DATA_WIDTH-1:0] HWDATA_S
);
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_SEQ  = 2'b11;
  localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);
  localparam logic [2:0] DEF_GNT = 3'(1 << DEFAULT_MASTER);
  logic [2:0] req, lock, grant_q, grant_d;
  logic [1:0] hmaster_q, hmaster_d, dmaster_q, dmaster_d, gidx, win;
  logic       mastlock_q, mastlock_d, hold, burst, hmaster_chg;
  assign req  = {HBUSREQ_M2, HBUSREQ_M1, HBUSREQ_M0};
  assign lock = {HLOCK_M2, HLOCK_M1, HLOCK_M0};
  assign gidx = grant_q[2] ? 2'd2 : grant_q[1] ? 2'd1 : 2'd0;
  assign {HGRANT_M2, HGRANT_M1, HGRANT_M0} = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;
  always_comb begin
    HADDR_S  = hmaster_q == 2'd2 ? HADDR_M2  : hmaster_q == 2'd1 ? HADDR_M1  : HADDR_M0;
    HTRANS_S = hmaster_q == 2'd2 ? HTRANS_M2 : hmaster_q == 2'd1 ? HTRANS_M1 : HTRANS_M0;
    HWRITE_S = hmaster_q == 2'd2 ? HWRITE_M2 : hmaster_q == 2'd1 ? HWRITE_M1 : HWRITE_M0;
    HWDATA_S = dmaster_q == 2'd2 ? HWDATA_M2 : dmaster_q == 2'd1 ? HWDATA_M1 : HWDATA_M0;
  end
  assign burst       = HTRANS_S == TR_BUSY || HTRANS_S == TR_SEQ;
  assign hmaster_chg = HREADY_S && gidx != hmaster_q;
`ifdef AHB_ARB_FIXED_PRIO_EN
  assign win  = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : DEF_IDX;
  assign hold = lock[gidx] || mastlock_q || burst;
`else
  localparam int TW = $clog2(MAX_TENURE + 1);
  logic [TW-1:0] tenure_q, tenure_d;
  logic [1:0]    rr_q, rr_d, c1, c2;
  // Scan order after the last winner: rr+1, rr+2, rr (mod 3).
  assign c1   = rr_q == 2'd2 ? 2'd0 : rr_q + 2'd1;
  assign c2   = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  assign win  = req[c1] ? c1 : req[c2] ? c2 : req[rr_q] ? rr_q : DEF_IDX;
  assign hold = lock[gidx] || mastlock_q || (burst && tenure_q < TW'(MAX_TENURE));
  always_comb begin
    rr_d     = (HREADY_S && !hold && |req && grant_d != grant_q) ? win : rr_q;
    tenure_d = tenure_q;
    if (hmaster_chg) tenure_d = '0;
    else if (HREADY_S && HTRANS_S[1] && tenure_q != TW'(MAX_TENURE)) tenure_d = tenure_q + TW'(1);
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_q     <= DEF_IDX;
      tenure_q <= '0;
    end else begin
      rr_q     <= rr_d;
      tenure_q <= tenure_d;
    end
  end
`endif
  always_comb begin
    grant_d    = (HREADY_S && !hold) ? 3'b001 << win : grant_q;
    hmaster_d  = HREADY_S ? gidx : hmaster_q;
    dmaster_d  = HREADY_S ? hmaster_q : dmaster_q;
    mastlock_d = HREADY_S ? lock[gidx] : mastlock_q;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q    <= DEF_GNT;
      hmaster_q  <= DEF_IDX;
      dmaster_q  <= DEF_IDX;
      mastlock_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      hmaster_q  <= hmaster_d;
      dmaster_q  <= dmaster_d;
      mastlock_q <= mastlock_d;
    end
  end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed self-checking bench for ahb_rr_arbiter (default build).
module tb_ahb_rr_arbiter;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  logic        HCLK = 1'b0, HRESETn = 1'b0, HREADY_S = 1'b1;
  logic        HBUSREQ_M0 = 0, HBUSREQ_M1 = 0, HBUSREQ_M2 = 0;
  logic        HLOCK_M0 = 0, HLOCK_M1 = 0, HLOCK_M2 = 0;
  logic [31:0] HADDR_M0 = 32'hA000_0000, HADDR_M1 = 32'hA000_0001, HADDR_M2 = 32'hA000_0002;
  logic [31:0] HWDATA_M0 = 32'hD000_0000, HWDATA_M1 = 32'hD000_0001, HWDATA_M2 = 32'hD000_0002;
  logic [1:0]  HTRANS_M0 = IDLE, HTRANS_M1 = IDLE, HTRANS_M2 = IDLE;
  logic        HWRITE_M0 = 1, HWRITE_M1 = 0, HWRITE_M2 = 1;
  logic        HGRANT_M0, HGRANT_M1, HGRANT_M2, HMASTLOCK, HWRITE_S;
  logic [1:0]  HMASTER, HTRANS_S;
  logic [31:0] HADDR_S, HWDATA_S;
  logic [2:0]  gnt;
  int          checks = 0, failures = 0;
  ahb_rr_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HBUSREQ_M0(HBUSREQ_M0), .HBUSREQ_M1(HBUSREQ_M1), .HBUSREQ_M2(HBUSREQ_M2),
    .HLOCK_M0(HLOCK_M0), .HLOCK_M1(HLOCK_M1), .HLOCK_M2(HLOCK_M2),
    .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1), .HADDR_M2(HADDR_M2),
    .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1), .HTRANS_M2(HTRANS_M2),
    .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1), .HWRITE_M2(HWRITE_M2),
    .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1), .HWDATA_M2(HWDATA_M2),
    .HREADY_S(HREADY_S),
    .HGRANT_M0(HGRANT_M0), .HGRANT_M1(HGRANT_M1), .HGRANT_M2(HGRANT_M2),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S), .HWDATA_S(HWDATA_S)
  );
  assign gnt = {HGRANT_M2, HGRANT_M1, HGRANT_M0};
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask
  initial begin
    repeat (2) tick;
    check("rst_gnt", 32'(gnt), 1);
    check("rst_hmaster", 32'(HMASTER), 0);
    check("rst_mastlock", 32'(HMASTLOCK), 0);
    check("rst_haddr", HADDR_S, HADDR_M0);
    check("rst_hwdata", HWDATA_S, HWDATA_M0);
    check("rst_hwrite", 32'(HWRITE_S), 1);
    HRESETn = 1'b1;
    repeat (2) tick;
    check("park_gnt", 32'(gnt), 1);
    // all request NONSEQ singles: M1, M2, M0, M1
    {HBUSREQ_M0, HBUSREQ_M1, HBUSREQ_M2} = 3'b111;
    {HTRANS_M0, HTRANS_M1, HTRANS_M2} = {NONSEQ, NONSEQ, NONSEQ};
    tick;
    check("rr1_gnt", 32'(gnt), 2);
    tick;
    check("rr2_gnt", 32'(gnt), 4);
    check("rr2_hmaster", 32'(HMASTER), 1);
    check("rr2_hwdata", HWDATA_S, HWDATA_M0);
    tick;
    check("rr3_gnt", 32'(gnt), 1);
    check("rr3_hmaster", 32'(HMASTER), 2);
    check("rr3_hwdata", HWDATA_S, HWDATA_M1);
    tick;
    check("rr4_gnt", 32'(gnt), 2);
    check("rr4_hmaster", 32'(HMASTER), 0);
    check("rr4_hwdata", HWDATA_S, HWDATA_M2);
    // M1 burst, tenure limit forces handover to M2
    {HBUSREQ_M0, HBUSREQ_M1, HBUSREQ_M2} = 3'b010;
    {HTRANS_M0, HTRANS_M1, HTRANS_M2} = {IDLE, IDLE, IDLE};
    tick;
    check("own_hmaster", 32'(HMASTER), 1);
    check("own_gnt", 32'(gnt), 2);
    HTRANS_M1 = NONSEQ;
    tick;
    HTRANS_M1 = SEQ;
    HBUSREQ_M2 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick;
      check("tenure_hold_gnt", 32'(gnt), 2);
    end
    check("tenure_hold_hmaster", 32'(HMASTER), 1);
    tick;
    check("tenure_break_gnt", 32'(gnt), 4);
    check("tenure_break_hmaster", 32'(HMASTER), 1);
    // M2 locked 20-beat burst while M0 requests
    HTRANS_M1 = IDLE;
    HBUSREQ_M1 = 1'b0;
    HLOCK_M2 = 1'b1;
    HBUSREQ_M0 = 1'b1;
    tick;
    check("lock_hmaster", 32'(HMASTER), 2);
    check("lock_mastlock", 32'(HMASTLOCK), 1);
    check("lock_hwdata", HWDATA_S, HWDATA_M1);
    for (int i = 0; i < 20; i++) begin
      HTRANS_M2 = (i == 0) ? NONSEQ : SEQ;
      tick;
      check("lock_beat_gnt", 32'(gnt), 4);
      check("lock_beat_mastlock", 32'(HMASTLOCK), 1);
    end
    HLOCK_M2 = 1'b0;
    HBUSREQ_M2 = 1'b0;
    HTRANS_M2 = IDLE;
    tick;
    check("lock_tail_gnt", 32'(gnt), 4);
    check("lock_tail_mastlock", 32'(HMASTLOCK), 0);
    tick;
    check("lock_done_gnt", 32'(gnt), 1);
    check("lock_done_hmaster", 32'(HMASTER), 2);
    // HREADY_S low freezes grant and owners
    HREADY_S = 1'b0;
    HBUSREQ_M1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("wait_hmaster", 32'(HMASTER), 2);
      check("wait_gnt", 32'(gnt), 1);
      check("wait_haddr", HADDR_S, HADDR_M2);
    end
    HREADY_S = 1'b1;
    HBUSREQ_M0 = 1'b0;
    tick;
    check("ready_hmaster", 32'(HMASTER), 0);
    check("ready_gnt", 32'(gnt), 2);
    check("ready_haddr", HADDR_S, HADDR_M0);
    check("ready_hwdata", HWDATA_S, HWDATA_M2);
    tick;
    check("ready2_hmaster", 32'(HMASTER), 1);
    check("ready2_hwdata", HWDATA_S, HWDATA_M0);
    check("ready2_gnt", 32'(gnt), 2);
    // asynchronous reset in the middle of a locked burst
    HLOCK_M1 = 1'b1;
    HTRANS_M1 = NONSEQ;
    tick;
    check("pre_rst_mastlock", 32'(HMASTLOCK), 1);
    HTRANS_M1 = SEQ;
    #3;
    HRESETn = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 1);
    check("arst_hmaster", 32'(HMASTER), 0);
    check("arst_mastlock", 32'(HMASTLOCK), 0);
    check("arst_haddr", HADDR_S, HADDR_M0);
    check("arst_hwdata", HWDATA_S, HWDATA_M0);
    tick;
    HRESETn = 1'b1;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
